// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared types and helpers for the rv32i pipeline control path.
//                pipe_ctrl_state_t - stall/flush controller state encoding.
//                raw_hazard()      - read-after-write match against a load in EX.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_ctrl_state_t;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    function automatic logic raw_hazard(
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  use_rs
    );
        return use_rs && (rd != '0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Ports       : clk, rst_n (async active-low), inc (count enable),
//                count [CNT_W-1:0] (current value)
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Stall/flush controller for the five-stage rv32i pipeline.
//                Freezes every stage while an instruction or data memory
//                access is outstanding, inserts a bubble into ID_EX on a
//                load-use hazard, and squashes IF_ID/ID_EX on an EX redirect.
//                Saturating counters track stall, bubble and flush events.
//  Ports       : clk, rst_n (async active-low)
//                imem_req/imem_resp, dmem_req/dmem_resp - memory handshakes
//                ID_rs1/ID_rs2/ID_use_rs1/ID_use_rs2    - ID-stage sources
//                ID_EX_rd/ID_EX_mem_read               - EX-stage load info
//                EX_redirect                           - taken branch / jump
//                load_pc, pc_sel_redirect              - PC control
//                *_load, *_flush                       - stage register control
//                stall_cnt, bubble_cnt, flush_cnt      - event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_req,
    input  logic                  imem_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    input  logic [REG_ADDR_W-1:0] ID_rs1,
    input  logic [REG_ADDR_W-1:0] ID_rs2,
    input  logic                  ID_use_rs1,
    input  logic                  ID_use_rs2,
    input  logic [REG_ADDR_W-1:0] ID_EX_rd,
    input  logic                  ID_EX_mem_read,
    input  logic                  EX_redirect,
    output logic                  load_pc,
    output logic                  pc_sel_redirect,
    output logic                  IF_ID_load,
    output logic                  ID_EX_load,
    output logic                  EX_MEM_load,
    output logic                  MEM_WB_load,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    pipe_ctrl_state_t state_q;
    pipe_ctrl_state_t state_d;
    logic             imem_done_q;
    logic             dmem_done_q;
    logic             imem_done_d;
    logic             dmem_done_d;
    logic             mem_stall;
    logic             load_use;
    logic             stall_inc;
    logic             bubble_inc;
    logic             flush_inc;

    // The done flags remember a response that came back while the other
    // side was still outstanding, so the earlier side stops stalling.
    assign mem_stall = (imem_req & ~(imem_resp | imem_done_q))
                     | (dmem_req & ~(dmem_resp | dmem_done_q));

    assign load_use = ID_EX_mem_read
                    & (raw_hazard(ID_EX_rd, ID_rs1, ID_use_rs1)
                     | raw_hazard(ID_EX_rd, ID_rs2, ID_use_rs2));

    // ------------------------------------------------------------------
    // State and sticky-flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, flags and stage control
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        imem_done_d     = 1'b0;
        dmem_done_d     = 1'b0;
        load_pc         = 1'b0;
        pc_sel_redirect = 1'b0;
        IF_ID_load      = 1'b0;
        ID_EX_load      = 1'b0;
        EX_MEM_load     = 1'b0;
        MEM_WB_load     = 1'b0;
        IF_ID_flush     = 1'b0;
        ID_EX_flush     = 1'b0;
        stall_inc       = 1'b0;
        bubble_inc      = 1'b0;
        flush_inc       = 1'b0;

        case (state_q)
            RUN:      if (mem_stall)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_stall) state_d = RUN;
            default:  state_d = RUN;
        endcase

        if (mem_stall) begin
            // Everything frozen; accumulate responses for the advance cycle.
            imem_done_d = imem_done_q | (imem_req & imem_resp);
            dmem_done_d = dmem_done_q | (dmem_req & dmem_resp);
            stall_inc   = 1'b1;
        end else if (EX_redirect) begin
            // Any hazard seen in ID is on the wrong path and is discarded.
            load_pc         = 1'b1;
            pc_sel_redirect = 1'b1;
            IF_ID_load      = 1'b1;
            ID_EX_load      = 1'b1;
            EX_MEM_load     = 1'b1;
            MEM_WB_load     = 1'b1;
            IF_ID_flush     = 1'b1;
            ID_EX_flush     = 1'b1;
            flush_inc       = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF_ID, drop a NOP into EX, let the load move on.
            ID_EX_load  = 1'b1;
            ID_EX_flush = 1'b1;
            EX_MEM_load = 1'b1;
            MEM_WB_load = 1'b1;
            bubble_inc  = 1'b1;
        end else begin
            load_pc     = 1'b1;
            IF_ID_load  = 1'b1;
            ID_EX_load  = 1'b1;
            EX_MEM_load = 1'b1;
            MEM_WB_load = 1'b1;
        end

        // Enables must be inactive the instant reset asserts, not a clock later.
        if (!rst_n) begin
            load_pc         = 1'b0;
            pc_sel_redirect = 1'b0;
            IF_ID_load      = 1'b0;
            ID_EX_load      = 1'b0;
            EX_MEM_load     = 1'b0;
            MEM_WB_load     = 1'b0;
            IF_ID_flush     = 1'b0;
            ID_EX_flush     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire
